shift_add_mult_ctrl: RTL and testbench

- Iterative unsigned WIDTH x WIDTH -> 2*WIDTH multiplier sequencer.
- Time-shares one instance of the team's 4-bit-block carry-bypass ripple adder (WIDTH bits, Cin tied 0) across WIDTH shift-add iterations.
- Sits between a requester issuing start/operands and the single shared adder; provides start/busy/done handshake and a held product register.

---
 rtl/shift_add_mult_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_shift_add_mult_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult_ctrl.sv
// Iterative unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier sequencer.
// One shared carry-bypass adder is reused once per multiplier bit.

module csba_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NB = WIDTH / 4;

  logic       carry_s;
  logic [3:0] xb_s;
  logic [3:0] yb_s;
  logic [4:0] rsum_s;
  logic       prop_s;

  // Ripple inside each 4-bit block; a fully propagating block forwards its carry-in directly
  always_comb begin
    carry_s = cin;
    sum     = {WIDTH{1'b0}};
    xb_s    = 4'b0000;
    yb_s    = 4'b0000;
    rsum_s  = 5'b00000;
    prop_s  = 1'b0;
    for (int i = 0; i < NB; i++) begin
      xb_s          = x[4*i +: 4];
      yb_s          = y[4*i +: 4];
      rsum_s        = {1'b0, xb_s} + {1'b0, yb_s} + {4'b0000, carry_s};
      sum[4*i +: 4] = rsum_s[3:0];
      prop_s        = &(xb_s ^ yb_s);
      if (prop_s) begin
        carry_s = carry_s;
      end else begin
        carry_s = rsum_s[4];
      end
    end
    cout = carry_s;
  end

endmodule

module shift_add_mult_ctrl #(
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_t               state_r;
  state_t               state_next_s;
  logic [WIDTH-1:0]     m_r;
  logic [WIDTH-1:0]     h_r;
  logic [WIDTH-1:0]     q_r;
  logic [CW-1:0]        count_r;
  logic                 busy_r;
  logic                 done_r;
  logic [2*WIDTH-1:0]   product_r;

  logic                 load_s;
  logic                 step_s;
  logic                 last_s;
  logic [WIDTH-1:0]     addend_s;
  logic [WIDTH-1:0]     sum_s;
  logic                 cout_s;

  // Multiplicand is added only when the current multiplier bit is set
  always_comb begin
    addend_s = {WIDTH{1'b0}};
    if (q_r[0]) begin
      addend_s = m_r;
    end else begin
      addend_s = {WIDTH{1'b0}};
    end
  end

  csba_adder #(.WIDTH(WIDTH)) u_adder (
    .x    (h_r),
    .y    (addend_s),
    .cin  (1'b0),
    .sum  (sum_s),
    .cout (cout_s)
  );

  assign last_s = (count_r == LAST_ITER);

  // Next-state and control decode
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    step_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          load_s       = 1'b1;
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          load_s       = 1'b1;
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == RUN);
      done_r  <= (state_next_s == DONE);
    end
  end

  // Datapath: operand capture and shift-add iteration; carry-out lands in H's MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_r     <= {WIDTH{1'b0}};
      h_r     <= {WIDTH{1'b0}};
      q_r     <= {WIDTH{1'b0}};
      count_r <= {CW{1'b0}};
    end else if (load_s) begin
      m_r     <= a;
      h_r     <= {WIDTH{1'b0}};
      q_r     <= b;
      count_r <= {CW{1'b0}};
    end else if (step_s) begin
      h_r     <= {cout_s, sum_s[WIDTH-1:1]};
      q_r     <= {sum_s[0], q_r[WIDTH-1:1]};
      count_r <= count_r + CW'(1);
    end else begin
      m_r     <= m_r;
      h_r     <= h_r;
      q_r     <= q_r;
      count_r <= count_r;
    end
  end

  // Product is written from the final iteration so it is valid alongside done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_r <= {(2*WIDTH){1'b0}};
    end else if (step_s && last_s) begin
      product_r <= {cout_s, sum_s, q_r[WIDTH-1:1]};
    end else begin
      product_r <= product_r;
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Scoreboard bench for shift_add_mult_ctrl: directed vectors, queued expectations,
// independent monitor comparing product and done timing.

module tb_shift_add_mult_ctrl;

  typedef struct {
    logic [63:0] prod;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  logic        start8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        done8;
  logic [15:0] product8;

  int   checks;
  int   fails;
  int   cyc;
  exp_t exp_q[$];

  shift_add_mult_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  shift_add_mult_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(product8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pop one expectation per done pulse
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      check("busy_done_exclusive", {63'd0, busy & done}, 64'd0);
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("product", product, e.prod);
          check("done_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic [63:0] ev);
    exp_t e;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    e.prod = ev; e.cyc = cyc + 1 + 32;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) check("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int n;
    int c0;
    exp_t e;
    checks = 0; fails = 0; cyc = 0;
    rst_n = 1'b0; start = 1'b0; a = 32'd0; b = 32'd0;
    start8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_product", product, 64'd0);
    rst_n = 1'b1;

    // 3*5 with busy duration check
    issue(32'd3, 32'd5, 64'h0000_0000_0000_000F);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", 64'(n), 64'd32);
    check("done_after_busy", {63'd0, done}, 64'd1);

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    wait_done();
    issue(32'h1234_5678, 32'd0, 64'd0);
    wait_done();
    issue(32'd0, 32'hDEAD_BEEF, 64'd0);
    wait_done();
    issue(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);
    wait_done();

    // start held through RUN with changing operands, then back-to-back launch from DONE
    @(negedge clk);
    a = 32'h0001_0001; b = 32'h0000_0100; start = 1'b1;
    e.prod = 64'h0000_0000_0100_0100; e.cyc = cyc + 1 + 32;
    exp_q.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      a = 32'hA5A5_A5A5 ^ 32'(n); b = 32'h5A5A_0000 + 32'(n);
      n++;
    end while (done !== 1'b1 && n < 100);
    check("b2b_first_done", {63'd0, done}, 64'd1);
    a = 32'h0000_FFFF; b = 32'h0001_0000;
    e.prod = 64'h0000_0000_FFFF_0000; e.cyc = cyc + 1 + 32;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = 32'h1111_1111; b = 32'h2222_2222;
    check("b2b_busy_next", {63'd0, busy}, 64'd1);
    check("b2b_product_held", product, 64'h0000_0000_0100_0100);
    wait_done();

    // Reset mid-RUN: no done, product cleared
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_product", product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'd7, 32'd9, 64'd63);
    wait_done();

    // WIDTH=8 instance
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (done8 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("w8_product", {48'd0, product8}, 64'h0000_0000_0000_FE01);
    check("w8_done_cycle", 64'(cyc), 64'(c0 + 1 + 8));

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
